// File: rtl/srl32_iter_if.sv
// Start/done bus between the CPU and the multi-cycle right shifter.
// SRL32_ITER_ROTATE_EN adds the rot request bit.
interface srl32_iter_if;
   logic        start;
   logic        arith;
   logic [31:0] A;
   logic [31:0] B;
   logic [31:0] res;
   logic        busy;
   logic        done;
`ifdef SRL32_ITER_ROTATE_EN
   logic        rot;

   modport master (
      output start, arith, A, B, rot,
      input  res, busy, done
   );
   modport slave (
      input  start, arith, A, B, rot,
      output res, busy, done
   );
`else
   modport master (
      output start, arith, A, B,
      input  res, busy, done
   );
   modport slave (
      input  start, arith, A, B,
      output res, busy, done
   );
`endif
endinterface

// File: rtl/srl32_iter.sv
// Multi-cycle SRL/SRA unit, up to STEP bit positions per cycle.
// SRL32_ITER_ROTATE_EN adds a rotate-right mode selected by rot.
module srl32_iter #(
   parameter int WIDTH   = 32,
   parameter int SHAMT_W = 5,
   parameter int STEP    = 4
) (
   input logic        clk,
   input logic        rst,
   srl32_iter_if.slave bus
);
   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   localparam logic [SHAMT_W-1:0] STEP_C = SHAMT_W'(STEP);

   state_t             state, state_nx;
   logic [WIDTH-1:0]   data, res_q, sh;
   logic [SHAMT_W-1:0] cnt, s;
   logic               fill, rot_q, accept;
   logic               busy, done;
   logic               unused_a;

   assign unused_a = ^{bus.A[31:11], bus.A[5:0]};
   assign accept   = bus.start && (state != SHIFT);
   assign s        = (cnt > STEP_C) ? STEP_C : cnt;

   // One bit position per unrolled stage, s stages active
   always_comb begin
      sh = data;
      for (int i = 0; i < STEP; i++) begin
         if (SHAMT_W'(i) < s)
            sh = {rot_q ? sh[0] : fill, sh[WIDTH-1:1]};
      end
   end

   always_comb begin
      state_nx = state;
      busy     = 1'b0;
      done     = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) state_nx = SHIFT;
         end
         SHIFT: begin
            busy = 1'b1;
            if (cnt == '0) state_nx = DONE;
         end
         DONE: begin
            done     = 1'b1;
            state_nx = accept ? SHIFT : IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nx;
   end

`ifdef SRL32_ITER_ROTATE_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst)         rot_q <= 1'b0;
      else if (accept) rot_q <= bus.rot;
   end
`else
   assign rot_q = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         data  <= '0;
         cnt   <= '0;
         fill  <= 1'b0;
         res_q <= '0;
      end else if (accept) begin
         data <= bus.B;
         cnt  <= bus.A[10:6];
         fill <= bus.arith & bus.B[WIDTH-1] & ~bus_rot();
      end else if (state == SHIFT) begin
         if (cnt == '0) begin
            res_q <= data;
         end else begin
            data <= sh;
            cnt  <= cnt - s;
         end
      end
   end

   function automatic logic bus_rot();
`ifdef SRL32_ITER_ROTATE_EN
      return bus.rot;
`else
      return 1'b0;
`endif
   endfunction

   assign bus.res  = res_q;
   assign bus.busy = busy;
   assign bus.done = done;
endmodule

// File: tb/tb_srl32_iter.sv
// Directed bench for srl32_iter: latency, fill modes, back-to-back,
// ignored start while busy and mid-shift reset.
module tb_srl32_iter;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   total = 0;
   int   passed = 0;
   int   lat;
   int   seen;
   logic got;

   always #5 clk = ~clk;

   srl32_iter_if bif ();

   srl32_iter dut (
      .clk (clk),
      .rst (rst),
      .bus (bif.slave)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
   endtask

   task automatic issue(input logic [31:0] a, input logic [31:0] b,
                        input logic ar, input logic rt);
      bif.start = 1'b1;
      bif.A     = a;
      bif.B     = b;
      bif.arith = ar;
`ifdef SRL32_ITER_ROTATE_EN
      bif.rot   = rt;
`else
      if (rt) $display("rot ignored in this build");
`endif
   endtask

   // Caller stands at a negedge; ends at the negedge after edge t
   task automatic fire(input string tag, input logic [31:0] a,
                       input logic [31:0] b, input logic ar,
                       input logic rt);
      issue(a, b, ar, rt);
      @(posedge clk);
      @(negedge clk);
      bif.start = 1'b0;
      chk({tag, "_busy"}, 32'(bif.busy), 32'd1);
      chk({tag, "_nodone"}, 32'(bif.done), 32'd0);
   endtask

   task automatic wait_done(input string tag, input int exp_lat,
                            input logic [31:0] exp_res);
      lat = 0;
      got = 1'b0;
      repeat (40) begin
         if (!got) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (bif.done) got = 1'b1;
         end
      end
      chk({tag, "_lat"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_res"}, bif.res, exp_res);
   endtask

   initial begin
      bif.start = 1'b0;
      bif.arith = 1'b0;
      bif.A     = '0;
      bif.B     = '0;
`ifdef SRL32_ITER_ROTATE_EN
      bif.rot   = 1'b0;
`endif
      repeat (2) @(negedge clk);
      chk("rst_res", bif.res, 32'h0);
      chk("rst_busy", 32'(bif.busy), 32'd0);
      chk("rst_done", 32'(bif.done), 32'd0);
      rst = 1'b0;
      @(negedge clk);

      fire("t1", 32'h100, 32'hF000_0000, 1'b0, 1'b0);
      wait_done("t1", 2, 32'h0F00_0000);

      @(negedge clk);
      fire("t2a", 32'h7C0, 32'h8000_0000, 1'b1, 1'b0);
      wait_done("t2a", 9, 32'hFFFF_FFFF);
      @(negedge clk);
      fire("t2l", 32'h7C0, 32'h8000_0000, 1'b0, 1'b0);
      wait_done("t2l", 9, 32'h0000_0001);

      @(negedge clk);
      fire("t3a", 32'h0, 32'h1234_5678, 1'b0, 1'b0);
      wait_done("t3a", 1, 32'h1234_5678);
      fire("t3b", 32'h200, 32'h1234_5678, 1'b0, 1'b0);
      wait_done("t3b", 3, 32'h0012_3456);

      @(negedge clk);
      fire("t4", 32'h400, 32'hABCD_0000, 1'b0, 1'b0);
      issue(32'h7C0, 32'hFFFF_FFFF, 1'b1, 1'b0);
      @(posedge clk);
      @(negedge clk);
      bif.start = 1'b0;
      wait_done("t4", 4, 32'h0000_ABCD);
      @(negedge clk);
      chk("t4_idle", 32'(bif.busy), 32'd0);
      chk("t4_hold", bif.res, 32'h0000_ABCD);

      fire("t5", 32'h500, 32'h0F0F_0000, 1'b0, 1'b0);
      @(posedge clk);
      #1 rst = 1'b1;
      @(negedge clk);
      chk("t5_res", bif.res, 32'h0);
      chk("t5_busy", 32'(bif.busy), 32'd0);
      chk("t5_done", 32'(bif.done), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (bif.done) seen++;
      end
      chk("t5_nodone", 32'(seen), 32'd0);

`ifdef SRL32_ITER_ROTATE_EN
      fire("t6r", 32'h100, 32'h0000_000F, 1'b1, 1'b1);
      wait_done("t6r", 2, 32'hF000_0000);
      @(negedge clk);
      fire("t6s", 32'h100, 32'h0000_000F, 1'b0, 1'b0);
      wait_done("t6s", 2, 32'h0000_0000);
`endif

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
